// File: rtl/keypad_scan_ctrl_if.sv
// Key delivery handshake between the keypad scanner (master) and the game logic (slave).
`timescale 1ns/1ps

interface keypad_scan_ctrl_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  overrun,
        output key_ack
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with press/release debounce and a valid/ack key output.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_CYCLES.
`timescale 1ns/1ps

module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic                      clk_50MHz_i,
    input  logic                      rst_async_la_i,
    input  logic [3:0]                columns_i,
    output logic [3:0]                rows_o,
    keypad_scan_ctrl_if.master        key_if
);

    localparam int unsigned DwW = $clog2(SCAN_DIV);
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DwW-1:0] DwLast = DwW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_params
        $error("keypad_scan_ctrl: SCAN_DIV must be >= 4, other periods nonzero");
    end

    typedef enum logic [1:0] {StScan, StPressDb, StHold} state_e;

    state_e           r_state;
    logic [3:0]       r_col_m;
    logic [3:0]       r_col_s;
    logic [3:0]       r_pat;
    logic [1:0]       r_row;
    logic [3:0]       r_rows;
    logic [DwW-1:0]   r_dwell;
    logic [DbW-1:0]   r_db;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_overrun;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RpW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RpW-1:0] RpLast = RpW'(REPEAT_CYCLES - 1);
    logic [RpW-1:0]   r_rep;
`endif

    logic             w_match;
    logic             w_emit;
    logic             w_take;
    logic [1:0]       w_row_nxt;
    logic [3:0]       w_code;

    // Simultaneous columns resolve to the lowest index.
    function automatic logic [1:0] lowest_col(input logic [3:0] pat);
        if (pat[0])      return 2'd0;
        else if (pat[1]) return 2'd1;
        else if (pat[2]) return 2'd2;
        else             return 2'd3;
    endfunction

    always_comb begin
        w_match   = (r_col_s == r_pat);
        w_row_nxt = r_row + 2'd1;
        w_emit    = (r_state == StPressDb) && w_match && (r_db == DbLast);
`ifdef KEYPAD_REPEAT_EN
        if ((r_state == StHold) && w_match && (r_rep == RpLast)) begin
            w_emit = 1'b1;
        end
`endif
        w_take    = w_emit && (!r_key_valid || key_if.key_ack);
        w_code    = {r_row, lowest_col(r_pat)};
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            r_state     <= StScan;
            r_col_m     <= 4'b0000;
            r_col_s     <= 4'b0000;
            r_pat       <= 4'b0000;
            r_row       <= 2'd0;
            r_rows      <= 4'b0001;
            r_dwell     <= '0;
            r_db        <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_col_m <= columns_i;
            r_col_s <= r_col_m;

            case (r_state)
                StScan: begin
                    if (r_dwell == DwLast) begin
                        r_dwell <= '0;
                        if (r_col_s == 4'b0000) begin
                            r_row  <= w_row_nxt;
                            r_rows <= 4'b0001 << w_row_nxt;
                        end else begin
                            r_pat   <= r_col_s;
                            r_db    <= '0;
                            r_state <= StPressDb;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                StPressDb: begin
                    if (!w_match) begin
                        r_state <= StScan;
                        r_row   <= w_row_nxt;
                        r_rows  <= 4'b0001 << w_row_nxt;
                        r_dwell <= '0;
                        r_db    <= '0;
                    end else if (r_db == DbLast) begin
                        r_db    <= '0;
                        r_state <= StHold;
`ifdef KEYPAD_REPEAT_EN
                        r_rep   <= '0;
`endif
                    end else begin
                        r_db <= r_db + 1'b1;
                    end
                end
                StHold: begin
                    // Release resumes scanning on the same row.
                    if (r_col_s != 4'b0000) begin
                        r_db <= '0;
                    end else if (r_db == DbLast) begin
                        r_db    <= '0;
                        r_dwell <= '0;
                        r_state <= StScan;
                    end else begin
                        r_db <= r_db + 1'b1;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (!w_match || r_rep == RpLast) begin
                        r_rep <= '0;
                    end else begin
                        r_rep <= r_rep + 1'b1;
                    end
`endif
                end
                default: r_state <= StScan;
            endcase

            // A dropped key sets overrun; that set beats an ack-driven clear.
            if (w_emit && !w_take) begin
                r_overrun <= 1'b1;
            end else if (r_key_valid && key_if.key_ack) begin
                r_overrun <= 1'b0;
            end

            if (w_take) begin
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
            end else if (key_if.key_ack) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign rows_o           = r_rows;
    assign key_if.key_code  = r_key_code;
    assign key_if.key_valid = r_key_valid;
    assign key_if.overrun   = r_overrun;

endmodule
